// File: rtl/axi4_lite_read_slave_responder_pkg.sv
// Shared types and default sizing for the AXI4-Lite read responder and its
// outstanding-request FIFO.
package Axi4LiteReadSlaveGlobalPkg;
  localparam int AXI_ADDRESS_WIDTH     = 32;
  localparam int AXI_DATA_WIDTH        = 32;
  localparam int AXI_DELAY_WIDTH       = 5;
  localparam int AXI_OUTSTANDING_DEPTH = 4;
  localparam logic [31:0] AXI_MIN_ADDRESS = 32'h0000_0001;
  localparam logic [31:0] AXI_MAX_ADDRESS = 32'h0000_00FF;
  localparam logic [31:0] AXI_SECURE_BASE = 32'h0000_0080;

  typedef enum logic [1:0] {
    RRESP_OKAY   = 2'b00,
    RRESP_EXOKAY = 2'b01,
    RRESP_SLVERR = 2'b10,
    RRESP_DECERR = 2'b11
  } rrespEnum;

  // Bit masks into arprot.
  typedef enum logic [2:0] {
    ARPROT_PRIVILEGED  = 3'b001,
    ARPROT_NONSECURE   = 3'b010,
    ARPROT_INSTRUCTION = 3'b100
  } arprotEnum;

  typedef enum logic [1:0] {IDLE, CAPTURE, DELAY, RESP} rStateEnum;

  typedef struct packed {
    logic [AXI_ADDRESS_WIDTH-1:0] addr;
    rrespEnum                     resp;
  } fifoEntryStruct;
endpackage

// File: rtl/axi4_lite_read_slave_responder_fifo.sv
// Synchronous FIFO for classified AR requests; pop_data shows the head entry
// combinationally.
module axi4_lite_read_slave_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/axi4_lite_read_slave_responder.sv
// AXI4-Lite read responder: classifies AR requests, queues them, and returns
// in-order R beats fetched from a 1-cycle-latency backing read port.
module axi4_lite_read_slave_responder
  import Axi4LiteReadSlaveGlobalPkg::*;
#(
  parameter int ADDRESS_WIDTH     = AXI_ADDRESS_WIDTH,
  parameter int DATA_WIDTH        = AXI_DATA_WIDTH,
  parameter int DELAY_WIDTH       = AXI_DELAY_WIDTH,
  parameter bit DEFAULT_READY     = 1'b0,
  parameter int OUTSTANDING_DEPTH = AXI_OUTSTANDING_DEPTH,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = ADDRESS_WIDTH'(AXI_MIN_ADDRESS),
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS = ADDRESS_WIDTH'(AXI_MAX_ADDRESS),
  parameter logic [ADDRESS_WIDTH-1:0] SECURE_BASE = ADDRESS_WIDTH'(AXI_SECURE_BASE)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [2:0]               arprot,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic [DELAY_WIDTH-1:0]   cfg_arready_delay,
  input  logic [DELAY_WIDTH-1:0]   cfg_rvalid_delay,
  output logic                     mem_rd_en,
  output logic [ADDRESS_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rd_data,
  output logic [4:0]               outstanding_count
);
  localparam int CW = $clog2(OUTSTANDING_DEPTH) + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    rrespEnum                 resp;
  } entry_t;

  rStateEnum              state, state_nxt;
  rrespEnum               ar_resp, cur_resp, rresp_q;
  entry_t                 head;
  logic                   ar_hs, fifo_pop, fifo_full, fifo_empty, capture;
  logic [CW-1:0]          fifo_count;
  logic [CW:0]            count_next;
  logic                   full_next;
  logic [DELAY_WIDTH-1:0] dly_cnt;

  assign ar_hs = arvalid && arready;

  always_comb begin
    ar_resp = RRESP_OKAY;
    if (araddr < MIN_ADDRESS || araddr > MAX_ADDRESS)
      ar_resp = RRESP_DECERR;
    else if (araddr[1:0] != 2'b00)
      ar_resp = RRESP_SLVERR;
    else if (araddr >= SECURE_BASE && (arprot & ARPROT_NONSECURE) != 3'b000)
      ar_resp = RRESP_SLVERR;
  end

  axi4_lite_read_slave_fifo #(.DEPTH(OUTSTANDING_DEPTH), .WIDTH($bits(entry_t))) u_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .push     (ar_hs),
    .push_data(entry_t'{addr: araddr, resp: ar_resp}),
    .pop      (fifo_pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Exact occupancy after this edge, so a registered arready never accepts into a full FIFO.
  assign count_next = {1'b0, fifo_count} + {{CW{1'b0}}, ar_hs} - {{CW{1'b0}}, fifo_pop};
  assign full_next  = (count_next == (CW+1)'(OUTSTANDING_DEPTH));
  assign outstanding_count = 5'(fifo_count) + {4'b0, state != IDLE};

  generate
    if (DEFAULT_READY) begin : g_ready_idle
      logic unused_cfg;
      assign unused_cfg = ^{cfg_arready_delay, fifo_full};
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) arready <= 1'b0;
        else          arready <= !full_next;
      end
    end else begin : g_ready_delay
      logic [DELAY_WIDTH-1:0] wait_cnt;
      logic [DELAY_WIDTH:0]   wait_inc;
      logic                   unused_full;
      assign unused_full = fifo_full;
      assign wait_inc    = {1'b0, wait_cnt} + 1'b1;
      // Single-cycle pulse once arvalid has waited cfg_arready_delay cycles.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          wait_cnt <= '0;
          arready  <= 1'b0;
        end else begin
          if (ar_hs)                          wait_cnt <= '0;
          else if (arvalid && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
          arready <= arvalid && !arready && !full_next &&
                     (wait_inc >= {1'b0, cfg_arready_delay});
        end
      end
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (cfg_rvalid_delay != '0) ? DELAY : RESP;
      DELAY:   if (dly_cnt <= DELAY_WIDTH'(1)) state_nxt = RESP;
      RESP:    if (rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop    = (state == IDLE) && !fifo_empty;
    mem_rd_en   = fifo_pop && (head.resp == RRESP_OKAY);
    mem_rd_addr = head.addr;
    capture     = (state == CAPTURE);
    rvalid      = (state == RESP);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cur_resp <= RRESP_OKAY;
      rresp_q  <= RRESP_OKAY;
      rdata    <= '0;
      dly_cnt  <= '0;
    end else begin
      if (fifo_pop) cur_resp <= head.resp;
      if (capture) begin
        rdata   <= (cur_resp == RRESP_OKAY) ? mem_rd_data : '0;
        rresp_q <= cur_resp;
        dly_cnt <= cfg_rvalid_delay;
      end else if (state == DELAY) begin
        dly_cnt <= dly_cnt - 1'b1;
      end
    end
  end

  assign rresp = rresp_q;
endmodule

// File: tb/tb_axi4_lite_read_slave_responder.sv
// Scoreboard bench: AR handshakes push reference-model responses, an
// independent monitor pops and compares every R beat and backing read.
module tb_axi4_lite_read_slave_responder;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  // Instance A: DEFAULT_READY=1
  logic [31:0] araddr, rdata, mem_rd_addr, mem_rd_data;
  logic [2:0]  arprot;
  logic        arvalid, arready, rvalid, rready, mem_rd_en;
  logic [1:0]  rresp;
  logic [4:0]  cfg_arready_delay, cfg_rvalid_delay, outstanding_count;
  // Instance B: DEFAULT_READY=0
  logic [31:0] b_araddr, b_rdata, b_mem_rd_addr, b_mem_rd_data;
  logic [2:0]  b_arprot;
  logic        b_arvalid, b_arready, b_rvalid, b_rready, b_mem_rd_en;
  logic [1:0]  b_rresp;
  logic [4:0]  b_cfg_arready_delay, b_cfg_rvalid_delay, b_outstanding_count;

  axi4_lite_read_slave_responder #(.DEFAULT_READY(1'b1)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .araddr(araddr), .arprot(arprot),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready), .cfg_arready_delay(cfg_arready_delay),
    .cfg_rvalid_delay(cfg_rvalid_delay), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .outstanding_count(outstanding_count));

  axi4_lite_read_slave_responder #(.DEFAULT_READY(1'b0)) u_dut_dr0 (
    .aclk(aclk), .aresetn(aresetn), .araddr(b_araddr), .arprot(b_arprot),
    .arvalid(b_arvalid), .arready(b_arready), .rdata(b_rdata), .rresp(b_rresp),
    .rvalid(b_rvalid), .rready(b_rready), .cfg_arready_delay(b_cfg_arready_delay),
    .cfg_rvalid_delay(b_cfg_rvalid_delay), .mem_rd_en(b_mem_rd_en),
    .mem_rd_addr(b_mem_rd_addr), .mem_rd_data(b_mem_rd_data),
    .outstanding_count(b_outstanding_count));

  int n_cmp = 0, n_err = 0;
  int unsigned cyc = 0, last_hs_cyc = 0;
  int mem_rd_cnt = 0, b_hs_cnt = 0;
  logic rr_rand = 1'b0, rr_fixed = 1'b1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] rd_q[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference decode: out of window, misaligned, non-secure into secure region.
  function automatic logic [1:0] ref_resp(input logic [31:0] a, input logic [2:0] p);
    if (a < 32'h1 || a > 32'hFF) return 2'b11;
    if (a % 4 != 0)              return 2'b10;
    if (a >= 32'h80 && p[1])     return 2'b10;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;
  always @(posedge aclk) if (mem_rd_en) mem_rd_data <= mem_fn(mem_rd_addr);
  always @(posedge aclk) if (b_mem_rd_en) b_mem_rd_data <= mem_fn(b_mem_rd_addr);
  always @(posedge aclk) begin
    #1 rready = rr_rand ? ($urandom_range(0, 1) == 1) : rr_fixed;
  end
  always @(negedge aclk) if (aresetn && b_arvalid && b_arready) b_hs_cnt++;

  // Monitor for instance A
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_resp;
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) prev_stall = 1'b0;
    else begin
      if (arvalid && arready) begin
        e.addr = araddr;
        e.resp = ref_resp(araddr, arprot);
        e.data = (e.resp == 2'b00) ? mem_fn(araddr) : 32'h0;
        exp_q.push_back(e);
        if (e.resp == 2'b00) rd_q.push_back(araddr);
        last_hs_cyc = cyc;
      end
      if (mem_rd_en) begin
        mem_rd_cnt++;
        if (rd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL mem_rd_unexpected: addr %0h with no OKAY request pending", mem_rd_addr);
        end else check("mem_rd_addr", mem_rd_addr, rd_q.pop_front());
      end
      if (prev_stall) begin
        check("rvalid_hold", rvalid, 1'b1);
        check("rdata_stable", rdata, prev_data);
        check("rresp_stable", rresp, prev_resp);
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: rdata %0h rresp %0h with no request pending", rdata, rresp);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rresp@%0h", e.addr), rresp, e.resp);
          check($sformatf("rdata@%0h", e.addr), rdata, e.data);
        end
      end
      prev_stall = rvalid && !rready;
      prev_data  = rdata;
      prev_resp  = rresp;
    end
  end

  task automatic do_ar(input logic [31:0] a, input logic [2:0] p);
    int t = 0;
    @(posedge aclk); #1;
    araddr = a; arprot = p; arvalid = 1'b1;
    while (t < 300) begin
      @(negedge aclk);
      if (arready) break;
      t++;
    end
    if (t >= 300) check("ar_timeout", 1'b0, 1'b1);
    @(posedge aclk); #1 arvalid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || rvalid) && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic lat_test(input logic [31:0] a, input int d);
    int t = 0;
    do_ar(a, 3'b000);
    while (!rvalid && t < 100) begin
      @(negedge aclk);
      t++;
    end
    check("rvalid_latency", cyc - last_hs_cyc, 3 + d);
  endtask

  task automatic b_ar_test(input logic [31:0] a, input int d);
    int waits = 0, t = 0, hs0;
    hs0 = b_hs_cnt;
    b_cfg_arready_delay = 5'(d);
    @(posedge aclk); #1;
    b_araddr = a; b_arprot = 3'b000; b_arvalid = 1'b1;
    while (waits < 100) begin
      @(negedge aclk);
      if (b_arready) break;
      waits++;
    end
    check("b_arready_wait", waits, d);
    @(posedge aclk); #1 b_arvalid = 1'b0;
    @(negedge aclk);
    check("b_arready_pulse", b_arready, 1'b0);
    while (!b_rvalid && t < 50) begin
      @(negedge aclk);
      t++;
    end
    check("b_rdata", b_rdata, mem_fn(a));
    check("b_rresp", b_rresp, 2'b00);
    check("b_single_hs", b_hs_cnt - hs0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, okay_n;
    logic [31:0] a;
    logic [2:0]  p;
    araddr = 0; arprot = 0; arvalid = 0;
    cfg_arready_delay = 0; cfg_rvalid_delay = 0;
    b_araddr = 0; b_arprot = 0; b_arvalid = 0; b_rready = 1'b1;
    b_cfg_arready_delay = 0; b_cfg_rvalid_delay = 0;
    repeat (3) @(negedge aclk);
    check("rst_arready", arready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rresp", rresp, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_outstanding", outstanding_count, 5'd0);
    check("rst_mem_rd_en", mem_rd_en, 1'b0);
    check("rst_b_arready", b_arready, 1'b0);
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    check("arready_idle_high", arready, 1'b1);

    // Basic latency and single backing read
    base = mem_rd_cnt;
    lat_test(32'h10, 0);
    drain();
    check("mem_rd_once", mem_rd_cnt - base, 1);

    // Classification
    base = mem_rd_cnt;
    do_ar(32'h200, 3'b000);
    do_ar(32'h12, 3'b000);
    do_ar(32'h90, 3'b010);
    do_ar(32'h90, 3'b000);
    drain();
    check("mem_rd_okay_only", mem_rd_cnt - base, 1);

    // Backpressure: 4 in FIFO + 1 held in RESP
    rr_fixed = 1'b0;
    repeat (2) @(negedge aclk);
    for (int i = 0; i < 5; i++) do_ar(32'h20 + 32'(4 * i), 3'b000);
    fork
      do_ar(32'h40, 3'b000);
      begin
        repeat (4) @(negedge aclk);
        check("full_outstanding", outstanding_count, 5'd5);
        check("full_arready", arready, 1'b0);
        rr_fixed = 1'b1;
      end
    join
    drain();

    // RVALID delay with random rready
    rr_rand = 1'b1;
    cfg_rvalid_delay = 5'd5;
    lat_test(32'h44, 5);
    for (int i = 0; i < 4; i++) do_ar(32'h48 + 32'(4 * i), 3'($urandom_range(0, 7)));
    drain();

    // Randomized mix
    base = mem_rd_cnt;
    okay_n = 0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(1, 63) * 4);
        1:       a = 32'($urandom_range(1, 255));
        2:       a = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(256, 65535));
        default: a = 32'($urandom_range(32, 63) * 4);
      endcase
      p = 3'($urandom_range(0, 7));
      if (ref_resp(a, p) == 2'b00) okay_n++;
      cfg_rvalid_delay = 5'($urandom_range(0, 3));
      do_ar(a, p);
    end
    drain();
    check("mem_rd_random", mem_rd_cnt - base, okay_n);

    // Reset while in RESP with two queued
    rr_rand = 1'b0;
    rr_fixed = 1'b0;
    cfg_rvalid_delay = 5'd0;
    repeat (2) @(negedge aclk);
    for (int i = 0; i < 3; i++) do_ar(32'h60 + 32'(4 * i), 3'b000);
    begin
      int t = 0;
      while (!rvalid && t < 50) begin
        @(negedge aclk);
        t++;
      end
    end
    check("pre_reset_outstanding", outstanding_count, 5'd3);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid, 1'b0);
    check("mid_rst_arready", arready, 1'b0);
    check("mid_rst_outstanding", outstanding_count, 5'd0);
    exp_q.delete();
    rd_q.delete();
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1 aresetn = 1'b1;
    rr_fixed = 1'b1;
    repeat (20) @(negedge aclk);
    lat_test(32'h10, 0);
    drain();

    // DEFAULT_READY=0 instance
    b_ar_test(32'h30, 3);
    b_ar_test(32'h34, 6);
    b_ar_test(32'h38, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_lite_read_slave_responder.md
Name: axi4_lite_read_slave_responder

Overview:
- Synthesizable AXI4-Lite read responder (slave end of the read channel pair), the counterpart of the read master VIP.
- Accepts AR requests into an outstanding-request FIFO and classifies each one (OKAY/SLVERR/DECERR).
- Fetches data from a 1-cycle-latency backing read port and returns R beats in order, with programmable ARREADY/RVALID wait states.
- Used as the DUT-side endpoint in the axi4Lite read environment and as a reusable register-file front end.

Parameters:
- ADDRESS_WIDTH, 32, araddr / mem_rd_addr width.
- DATA_WIDTH, 32, rdata / mem_rd_data width.
- DELAY_WIDTH, 5, width of wait-state configuration inputs.
- DEFAULT_READY, 0, 1 = arready idles high whenever FIFO not full; 0 = arready pulses after cfg_arready_delay.
- OUTSTANDING_DEPTH, 4, FIFO depth; power of 2, 2..16.
- MIN_ADDRESS, 32'h0000_0001, lowest decoded address.
- MAX_ADDRESS, 32'h0000_00FF, highest decoded address.
- SECURE_BASE, 32'h0000_0080, addresses >= this require secure access (arprot[1]=0).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- araddr  in  ADDRESS_WIDTH  read address
- arprot  in  3  protection type
- arvalid  in  1  address valid
- arready  out  1  address ready
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  master ready
- cfg_arready_delay  in  DELAY_WIDTH  ARREADY wait cycles (DEFAULT_READY=0 only)
- cfg_rvalid_delay  in  DELAY_WIDTH  wait cycles before RVALID
- mem_rd_en  out  1  backing read strobe
- mem_rd_addr  out  ADDRESS_WIDTH  backing read address
- mem_rd_data  in  DATA_WIDTH  backing data, valid the cycle after mem_rd_en
- outstanding_count  out  5  FIFO occupancy plus 1 if the R FSM is not IDLE

Behaviour:
Reset:
- aresetn low asynchronously clears arready, rvalid, rdata, rresp (=00), mem_rd_en, the FIFO, all counters and outstanding_count; FSM goes to IDLE.
- Reset mid-transaction discards all pending requests. No R beat is issued for them.

AR channel:
- A handshake occurs on an edge where arvalid and arready are both high.
- Classification at handshake, in priority order:
  - addr < MIN_ADDRESS or addr > MAX_ADDRESS -> DECERR (11).
  - araddr[1:0] != 0 -> SLVERR (10).
  - addr >= SECURE_BASE with arprot[1]=1 -> SLVERR.
  - Otherwise -> OKAY (00).
- The FIFO entry holds {araddr, rresp}.
- DEFAULT_READY=1: arready is a register equal to !full_next; it may be high with arvalid low.
- DEFAULT_READY=0: a wait counter increments each cycle arvalid is high with no handshake. arready is a 1-cycle pulse, registered, when counter == cfg_arready_delay and FIFO not full. Counter clears on handshake.
- FIFO full: arready is held low and arvalid stalls. Simultaneous push and pop is allowed when full.

R channel FSM:
- IDLE: FIFO non-empty -> pop. If the entry is OKAY, assert mem_rd_en (1 cycle) with mem_rd_addr = entry addr. Go to CAPTURE.
- CAPTURE: latch rdata = mem_rd_data for OKAY, else 0. Latch rresp. Load delay counter from cfg_rvalid_delay. Go to DELAY if nonzero, else RESP.
- DELAY: decrement; at 1 -> RESP.
- RESP: rvalid = 1. rdata and rresp are held stable until rready. On handshake -> IDLE with rvalid = 0.
- Error entries never assert mem_rd_en.
- Latency with both delays 0 and DEFAULT_READY=1: rvalid rises at the 2nd edge after the AR-handshake edge. The next response starts no sooner than 1 cycle after the R handshake.
- Responses are strictly in AR order. rvalid never drops without a handshake.
- Changing cfg inputs affects only counters loaded after the change.

Decomposition:
- Shared package Axi4LiteReadSlaveGlobalPkg holds:
  - the width/delay/depth parameters;
  - rrespEnum (OKAY/EXOKAY/SLVERR/DECERR);
  - arprotEnum;
  - the R-FSM state enum {IDLE, CAPTURE, DELAY, RESP};
  - a FIFO-entry struct {addr, resp}.
- One sub-module: axi4_lite_read_slave_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterized by depth and entry width, using the same aclk/aresetn.

Test Plan:
- DEFAULT_READY=1, delays 0, mem returns 32'hDEAD_BEEF for addr 32'h10: AR 32'h10, rready=1 -> rvalid at edge +2 with rdata 32'hDEAD_BEEF, rresp 00, exactly one mem_rd_en.
- AR 32'h200 -> rresp 11, rdata 0, no mem_rd_en. AR 32'h12 -> rresp 10. AR 32'h90 with arprot=3'b010 -> rresp 10. AR 32'h90 with arprot=0 -> OKAY.
- DEFAULT_READY=0, cfg_arready_delay=3, arvalid held -> arready pulses after 3 waiting cycles, a single handshake.
- rready held low with 6 back-to-back ARs, depth 4 -> arready low once 4 are in the FIFO plus 1 held in the R FSM (outstanding_count=5). Releasing rready drains all 6 in order, each with the correct data.
- cfg_rvalid_delay=5, rready toggling randomly -> rvalid appears 5 cycles after CAPTURE, and rdata/rresp stay stable while rvalid && !rready.
- aresetn pulled low while in RESP with 2 entries queued -> rvalid, arready, outstanding_count = 0 immediately. After release, no stale R beat; a new AR completes normally.
